if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised successor of the single-register instruction-fetch stage.
- Contains a PC generator, a pipelined request port to a synchronous instruction memory with 1-cycle read latency, and a DEPTH-entry prefetch FIFO.
- Talks to decode through a valid/ready handshake, which replaces the freeze input.
- Branch redirects flush the FIFO and discard any in-flight response.

Parameters:
- ADDR_W, 32, PC/address width
- INSTR_W, 32, instruction width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_PC, 0, PC value loaded at reset
- PC_STEP, 4, sequential PC increment
- BR_SHIFT, 2, left shift applied to br_offset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- br_taken  in  1  redirect request, single-cycle pulse
- br_pc  in  ADDR_W  PC of the branch instruction
- br_offset  in  ADDR_W  signed word offset
- imem_req  out  1  memory read request
- imem_addr  out  ADDR_W  read address
- imem_rdata  in  INSTR_W  read data, valid exactly 1 cycle after imem_req
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts
- out_pc  out  ADDR_W  PC of the head entry
- out_instr  out  INSTR_W  instruction of the head entry
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count

Behaviour:
- Single clock domain. rst is sampled on posedge clk only and is active-low.
- Reset values while rst=0:
  - fetch_pc=RESET_PC
  - FIFO empty, occupancy=0
  - inflight=0
  - imem_req=0, out_valid=0
  - out_pc=0, out_instr=0
- First imem_req=1 with imem_addr=RESET_PC occurs in the first cycle after rst returns to 1.
- Reset asserted mid-operation drops all FIFO contents and in-flight responses in the same edge.
- Issue rule:
  - imem_req = rst & ~br_taken & (occupancy + inflight < DEPTH).
  - imem_addr = fetch_pc.
  - On issue, fetch_pc += PC_STEP (modulo 2^ADDR_W; wrap-around is silent).
  - inflight=1 for the following cycle.
- Response:
  - In the cycle after an issue, if that request is not squashed, {issued_pc, imem_rdata} is pushed at the end of the cycle.
  - The entry is visible on out_* the next cycle.
  - Latency from imem_req to out_valid is 2 cycles.
- Pop: out_valid & out_ready removes the head at the clock edge.
- Same-cycle push and pop are allowed and leave occupancy unchanged.
- A pop frees a slot for the issue rule only from the next cycle. Issue is gated by registered occupancy.
- Full FIFO: no issue occurs. The accounting guarantees no overflow, so no push is ever dropped.
- Empty FIFO: out_valid=0. out_pc/out_instr hold their last values and are don't-care.
- Redirect (br_taken=1 in cycle t):
  - target = br_pc + (br_offset << BR_SHIFT), ADDR_W-bit truncated, two's complement.
  - At the end of t: FIFO cleared, occupancy=0, fetch_pc=target.
  - The response arriving in t+1 for any request issued before t+1 is discarded, tracked by a squash flag.
  - No request is issued in t.
  - Request to target in t+1; out_valid for target in t+3.
  - A pop handshake in cycle t is ignored: the flush wins.
- br_taken while rst=0 has no effect.
- Back-to-back redirects: the last one wins; each one restarts the sequence above.
- FIFO order is strictly in-order. No entry is visible before its push edge.
- Steady state with out_ready=1 and no redirects: one instruction per cycle.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- When defined, two extra outputs exist:
  - perf_fetched (32 bits): increments on each pop handshake.
  - perf_flushed (32 bits): increments by the number of entries discarded on each redirect, i.e. occupancy plus 1 if a live response is squashed.
- Both counters reset to 0 and wrap modulo 2^32.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset release, out_ready=1, memory returns addr^32'hA5A5_0000 → imem_addr sequence 0,4,8,… one per cycle from cycle 1; out_valid rises in cycle 3 with out_pc=0, out_instr=32'hA5A5_0000.
- Hold out_ready=0 for 10 cycles → occupancy saturates at 4; imem_req stays 0 once occupancy+inflight=4; on release, entries PC 0,4,8,12 are popped in order with none lost or duplicated.
- br_taken with br_pc=0x100, br_offset=-2 while FIFO holds 3 entries → occupancy=0 next cycle, imem_addr=0xF8 in t+1, stale response dropped, out_pc=0xF8 in t+3.
- br_taken in the same cycle as a pop handshake, and on two consecutive cycles → flush wins; only the second target (e.g. 0x200) is fetched.
- fetch_pc=RESET_PC=32'hFFFF_FFFC → next imem_addr=0 (wrap).
- rst=0 for one cycle mid-stream with a full FIFO → next cycle out_valid=0, occupancy=0, imem_addr=RESET_PC; with IF_FETCH_PERF_EN, the perf counters read 0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC generator, 1-cycle-latency memory request port and a
// DEPTH-entry prefetch FIFO to decode. Define IF_FETCH_PERF_EN to add perf counters.
module if_fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4,
  parameter int unsigned       BR_SHIFT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     br_taken,
  input  logic [ADDR_W-1:0]        br_pc,
  input  logic [ADDR_W-1:0]        br_offset,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_flushed
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  issued_pc_q;
  logic [ADDR_W-1:0]  br_target;
  logic               inflight_q;
  logic               squash_q;
  logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic               live_rsp;
  logic               push;
  logic               pop;

  assign br_target = br_pc + (br_offset << BR_SHIFT);

  // Issue is gated by registered occupancy plus the outstanding request, so a
  // slot freed by a pop only becomes usable in the following cycle.
  always_comb begin
    imem_req  = rst & ~br_taken & ((count_q + CntW'(inflight_q)) < CntW'(DEPTH));
    imem_addr = fetch_pc_q;
  end

  always_comb begin
    live_rsp  = inflight_q & ~squash_q;
    push      = live_rsp & ~br_taken;
    out_valid = rst & (count_q != '0);
    pop       = out_valid & out_ready & ~br_taken;
    out_pc    = pc_mem_q[rd_ptr_q];
    out_instr = instr_mem_q[rd_ptr_q];
    occupancy = count_q;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    if (br_taken) begin
      fetch_pc_d = br_target;
      count_d    = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
      squash_q    <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= imem_req;
      // Marks the response of any pre-redirect request as stale.
      squash_q   <= br_taken;
      count_q    <= count_d;
      if (imem_req) begin
        issued_pc_q <= fetch_pc_q;
      end
      if (br_taken) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          pc_mem_q[wr_ptr_q]    <= issued_pc_q;
          instr_mem_q[wr_ptr_q] <= imem_rdata;
          wr_ptr_q              <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetched_q;
  logic [31:0] flushed_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (pop) begin
        fetched_q <= fetched_q + 32'd1;
      end
      // Discarded entries: everything queued plus a response landing this cycle.
      if (br_taken) begin
        flushed_q <= flushed_q + 32'(count_q) + 32'(live_rsp);
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: stimulus loads expected fetch streams, a
// negedge monitor checks every decode handshake in order.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, br_taken, out_ready;
  logic [31:0] br_pc, br_offset;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, imem_rdata, out_pc, out_instr;
  logic [2:0]  occupancy;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_instr;
  logic [31:0] w_rdata = 32'h0;
  logic [2:0]  w_occ;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, w_pf, w_pfl;
  logic [31:0] flushed0;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t exp_q[$];

  if_fetch_queue u_dut (
    .clk        (clk),
    .rst        (rst),
    .br_taken   (br_taken),
    .br_pc      (br_pc),
    .br_offset  (br_offset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .occupancy  (occupancy)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  if_fetch_queue #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk        (clk),
    .rst        (rst),
    .br_taken   (1'b0),
    .br_pc      (32'h0),
    .br_offset  (32'h0),
    .imem_req   (w_req),
    .imem_addr  (w_addr),
    .imem_rdata (w_rdata),
    .out_valid  (w_valid),
    .out_ready  (1'b1),
    .out_pc     (w_pc),
    .out_instr  (w_instr),
    .occupancy  (w_occ)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched (w_pf),
    .perf_flushed (w_pfl)
`endif
  );

  // Synchronous memory: data for the address presented is returned one cycle later.
  always @(posedge clk) imem_rdata <= imem_addr ^ 32'hA5A5_0000;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic restart(input logic [31:0] start);
    ent_t e;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      e.pc    = start + 32'(4 * i);
      e.instr = e.pc ^ 32'hA5A5_0000;
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a redirect or reset in the same cycle cancels the handshake.
  always @(negedge clk) begin
    ent_t e;
    if (rst && !br_taken && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got pc %h expected no entry", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", out_pc, e.pc);
        chk("pop_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    rst = 1'b0; br_taken = 1'b0; br_pc = '0; br_offset = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);

    // Release reset with decode always ready.
    step();
    rst = 1'b1; out_ready = 1'b1; restart(32'h0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("run_req", 32'(imem_req), 32'd1);
      chk("run_addr", imem_addr, 32'(4 * (c - 1)));
      chk("run_valid", 32'(out_valid), 32'(c >= 3));
      if (c == 1) chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      if (c == 2) chk("wrap_addr1", w_addr, 32'h0);
      step();
    end

    // Stall decode: FIFO fills and issue stops.
    out_ready = 1'b0;
    for (int c = 7; c <= 16; c++) begin
      @(negedge clk);
      if (c >= 9) chk("stall_req", 32'(imem_req), 32'd0);
      if (c == 16) chk("stall_occ", 32'(occupancy), 32'd4);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop_slot_late_req", 32'(imem_req), 32'd0);
    chk("pop_slot_late_occ", 32'(occupancy), 32'd4);
    step();
    @(negedge clk);
    chk("refill_req", 32'(imem_req), 32'd1);
    chk("refill_addr", imem_addr, 32'd32);
    repeat (5) step();

    // Fill, pop one, let one request go out, then redirect with 3 queued.
    out_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (occupancy == 3'd4) begin
        ok = 1'b1;
        break;
      end
    end
    chk("fill_wait", 32'(ok), 32'd1);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    br_taken = 1'b1; br_pc = 32'h100; br_offset = 32'hFFFF_FFFE;
    @(negedge clk);
    chk("redir_occ_before", 32'(occupancy), 32'd3);
    chk("redir_req_blocked", 32'(imem_req), 32'd0);
`ifdef IF_FETCH_PERF_EN
    flushed0 = perf_flushed;
`endif
    step();
    br_taken = 1'b0; out_ready = 1'b1; restart(32'hF8);
    @(negedge clk);
    chk("redir_occ", 32'(occupancy), 32'd0);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'hF8);
    chk("redir_valid1", 32'(out_valid), 32'd0);
`ifdef IF_FETCH_PERF_EN
    chk("perf_flushed_delta", perf_flushed - flushed0, 32'd4);
`endif
    step();
    @(negedge clk);
    chk("redir_valid2", 32'(out_valid), 32'd0);
    chk("redir_addr2", imem_addr, 32'hFC);
    step();
    @(negedge clk);
    chk("redir_valid3", 32'(out_valid), 32'd1);
    chk("redir_pc3", out_pc, 32'hF8);
    repeat (4) step();

    // Redirect during a pop, then again next cycle: only the second target runs.
    br_taken = 1'b1; br_pc = 32'h300; br_offset = 32'h4;
    @(negedge clk);
    chk("b2b_valid_at_pop", 32'(out_valid), 32'd1);
`ifdef IF_FETCH_PERF_EN
    flushed0 = perf_flushed;
`endif
    step();
    br_pc = 32'h1F0; br_offset = 32'h4;
    @(negedge clk);
    chk("b2b_occ", 32'(occupancy), 32'd0);
    chk("b2b_req", 32'(imem_req), 32'd0);
    step();
    br_taken = 1'b0; restart(32'h200);
    @(negedge clk);
    chk("b2b_addr", imem_addr, 32'h200);
    chk("b2b_req2", 32'(imem_req), 32'd1);
`ifdef IF_FETCH_PERF_EN
    chk("b2b_flushed_delta", perf_flushed - flushed0, 32'd2);
`endif
    step();
    @(negedge clk);
    chk("b2b_valid3", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("b2b_valid4", 32'(out_valid), 32'd1);
    chk("b2b_pc4", out_pc, 32'h200);
    repeat (3) step();

    // Mid-stream reset with a full FIFO.
    out_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (occupancy == 3'd4) begin
        ok = 1'b1;
        break;
      end
    end
    chk("fill_wait2", 32'(ok), 32'd1);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1; out_ready = 1'b1; restart(32'h0);
    @(negedge clk);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_occ", 32'(occupancy), 32'd0);
    chk("mrst_req", 32'(imem_req), 32'd1);
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_pc", out_pc, 32'h0);
`ifdef IF_FETCH_PERF_EN
    chk("mrst_perf_fetched", perf_fetched, 32'd0);
    chk("mrst_perf_flushed", perf_flushed, 32'd0);
`endif
    step();
    step();
    @(negedge clk);
    chk("mrst_valid3", 32'(out_valid), 32'd1);
    chk("mrst_pc3", out_pc, 32'h0);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
